// File: rtl/modulo_buffer_requisicoes.sv
// Request buffer in front of the counter FSM: a DEPTH-entry FIFO feeding an
// output register that the counter loads from, popped by the FSM's Clear_Reg.
module modulo_buffer_requisicoes #(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 4,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  Clear_Reg,
    output logic [DATA_WIDTH-1:0] reg_data,
    output logic                  Load_Reg,
    output logic                  EmptyBuffer,
    output logic                  FullBuffer,
    output logic [CW-1:0]         count,
    output logic                  overflow
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;

    logic free_reg;
    logic deq;
    logic bypass;
    logic enq;
    logic drop;

    // A full FIFO still accepts a push when its head moves into the register
    // on the same edge, so occupancy stays at DEPTH.
    always_comb begin
        free_reg = ~Load_Reg | Clear_Reg;
        deq      = free_reg & (count != '0);
        bypass   = free_reg & (count == '0) & push;
        enq      = push & ~bypass & ((count < CW'(DEPTH)) | deq);
        drop     = push & ~bypass & ~enq;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            reg_data <= '0;
            Load_Reg <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (!enable) begin
            overflow <= 1'b0;
        end else begin
            overflow <= drop;
            if (free_reg) begin
                if (deq) begin
                    reg_data <= mem[rd_ptr];
                    Load_Reg <= 1'b1;
                end else if (bypass) begin
                    reg_data <= data_in;
                    Load_Reg <= 1'b1;
                end else begin
                    Load_Reg <= 1'b0;
                end
            end
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (rst && enable && enq) mem[wr_ptr] <= data_in;
    end

    assign EmptyBuffer = (count == '0);
    assign FullBuffer  = (count == CW'(DEPTH));

endmodule

// File: tb/tb_modulo_buffer_requisicoes.sv
// Directed vector table for the scenario corners, then random traffic checked
// against a queue-based model of the request buffer.
module tb_modulo_buffer_requisicoes;

    localparam int DW    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst, enable, push, Clear_Reg;
    logic [DW-1:0] data_in;
    logic [DW-1:0] reg_data;
    logic          Load_Reg, EmptyBuffer, FullBuffer, overflow;
    logic [CW-1:0] count;

    modulo_buffer_requisicoes #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .enable(enable), .push(push), .data_in(data_in),
        .Clear_Reg(Clear_Reg), .reg_data(reg_data), .Load_Reg(Load_Reg),
        .EmptyBuffer(EmptyBuffer), .FullBuffer(FullBuffer), .count(count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst, en, push;
        logic [DW-1:0] din;
        logic          clr;
        logic [DW-1:0] e_data;
        logic          e_load, e_empty, e_full;
        logic [CW-1:0] e_cnt;
        logic          e_ovf;
    } vec_t;

    vec_t vecs [$];
    int   n_pass = 0;
    int   n_tot  = 0;

    // Reference model: a plain queue behind a single valid/data register.
    logic [DW-1:0] q [$];
    logic [DW-1:0] m_data = '0;
    logic          m_valid = 1'b0;
    logic          m_ovf = 1'b0;

    function automatic void model_step(input logic r, input logic en, input logic p,
                                       input logic [DW-1:0] d, input logic c);
        logic taken;
        if (!r) begin
            q.delete();
            m_data = '0; m_valid = 1'b0; m_ovf = 1'b0;
        end else if (!en) begin
            m_ovf = 1'b0;
        end else begin
            taken = 1'b0;
            m_ovf = 1'b0;
            if (!m_valid || c) begin
                if (q.size() > 0) begin
                    m_data = q.pop_front(); m_valid = 1'b1;
                end else if (p) begin
                    m_data = d; m_valid = 1'b1; taken = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
            if (p && !taken) begin
                if (q.size() < DEPTH) q.push_back(d);
                else m_ovf = 1'b1;
            end
        end
    endfunction

    task automatic apply(input logic r, input logic en, input logic p,
                         input logic [DW-1:0] d, input logic c);
        rst = r; enable = en; push = p; data_in = d; Clear_Reg = c;
        @(posedge clk);
        model_step(r, en, p, d, c);
        #1;
    endtask

    task automatic check(input string name, input logic [DW-1:0] ed, input logic el,
                         input logic ee, input logic ef, input logic [CW-1:0] ec,
                         input logic eo);
        n_tot++;
        if (reg_data === ed && Load_Reg === el && EmptyBuffer === ee &&
            FullBuffer === ef && count === ec && overflow === eo)
            n_pass++;
        else
            $display("FAIL %s: got data=%0d load=%b empty=%b full=%b cnt=%0d ovf=%b, want data=%0d load=%b empty=%b full=%b cnt=%0d ovf=%b",
                     name, reg_data, Load_Reg, EmptyBuffer, FullBuffer, count, overflow,
                     ed, el, ee, ef, ec, eo);
    endtask

    function automatic void v(input logic r, input logic en, input logic p,
                              input logic [DW-1:0] d, input logic c,
                              input logic [DW-1:0] ed, input logic el, input logic ee,
                              input logic ef, input logic [CW-1:0] ec, input logic eo);
        vec_t t;
        t.rst = r; t.en = en; t.push = p; t.din = d; t.clr = c;
        t.e_data = ed; t.e_load = el; t.e_empty = ee; t.e_full = ef;
        t.e_cnt = ec; t.e_ovf = eo;
        vecs.push_back(t);
    endfunction

    initial begin
        rst = 1'b0; enable = 1'b1; push = 1'b0; data_in = '0; Clear_Reg = 1'b0;

        //  rst en push din clr | data load empty full cnt ovf
        // reset with push held, then idle release
        v(0, 1, 1, 7, 0,   0, 0, 1, 0, 0, 0);
        v(0, 1, 1, 7, 0,   0, 0, 1, 0, 0, 0);
        v(1, 1, 0, 0, 0,   0, 0, 1, 0, 0, 0);
        // bypass then queue
        v(1, 1, 1, 5, 0,   5, 1, 1, 0, 0, 0);
        v(1, 1, 1, 9, 0,   5, 1, 0, 0, 1, 0);
        v(1, 1, 1, 2, 0,   5, 1, 0, 0, 2, 0);
        v(1, 1, 0, 0, 1,   9, 1, 0, 0, 1, 0);
        // full and overflow
        v(0, 1, 0, 0, 0,   0, 0, 1, 0, 0, 0);
        v(1, 1, 1, 1, 0,   1, 1, 1, 0, 0, 0);
        v(1, 1, 1, 2, 0,   1, 1, 0, 0, 1, 0);
        v(1, 1, 1, 3, 0,   1, 1, 0, 0, 2, 0);
        v(1, 1, 1, 4, 0,   1, 1, 0, 0, 3, 0);
        v(1, 1, 1, 5, 0,   1, 1, 0, 1, 4, 0);
        v(1, 1, 1, 6, 0,   1, 1, 0, 1, 4, 1);
        v(1, 1, 1, 7, 1,   2, 1, 0, 1, 4, 0);
        // continuous pop across pointer wrap
        v(1, 1, 0, 0, 1,   3, 1, 0, 0, 3, 0);
        v(1, 1, 0, 0, 1,   4, 1, 0, 0, 2, 0);
        v(1, 1, 0, 0, 1,   5, 1, 0, 0, 1, 0);
        v(1, 1, 0, 0, 1,   7, 1, 1, 0, 0, 0);
        v(1, 1, 0, 0, 1,   7, 0, 1, 0, 0, 0);
        // enable freeze with count=2
        v(1, 1, 1, 1, 0,   1, 1, 1, 0, 0, 0);
        v(1, 1, 1, 2, 0,   1, 1, 0, 0, 1, 0);
        v(1, 1, 1, 3, 0,   1, 1, 0, 0, 2, 0);
        v(1, 0, 1, 15, 1,  1, 1, 0, 0, 2, 0);
        v(1, 0, 1, 15, 1,  1, 1, 0, 0, 2, 0);
        v(1, 0, 1, 15, 1,  1, 1, 0, 0, 2, 0);
        v(1, 1, 0, 0, 0,   1, 1, 0, 0, 2, 0);
        v(1, 1, 0, 0, 1,   2, 1, 0, 0, 1, 0);
        // reset mid-operation with count=3
        v(1, 1, 1, 4, 0,   2, 1, 0, 0, 2, 0);
        v(1, 1, 1, 5, 0,   2, 1, 0, 0, 3, 0);
        v(0, 1, 1, 9, 1,   0, 0, 1, 0, 0, 0);
        v(1, 1, 0, 0, 0,   0, 0, 1, 0, 0, 0);
        v(1, 1, 1, 10, 0, 10, 1, 1, 0, 0, 0);

        @(negedge clk);
        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].en, vecs[i].push, vecs[i].din, vecs[i].clr);
            check($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_load,
                  vecs[i].e_empty, vecs[i].e_full, vecs[i].e_cnt, vecs[i].e_ovf);
        end

        // overflow pulse is forced low by a freeze on the following edge
        for (int i = 0; i < 5; i++) apply(1, 1, 1, DW'(i + 3), 0);
        check("ovf_pre_freeze", m_data, m_valid, q.size() == 0, q.size() == DEPTH,
              CW'(q.size()), m_ovf);
        apply(1, 0, 1, 4'hc, 1);
        check("ovf_freeze", 4'd10, 1'b1, 1'b0, 1'b1, CW'(DEPTH), 1'b0);

        for (int i = 0; i < 400; i++) begin
            logic r, en, p, c;
            r  = ($urandom_range(0, 49) != 0);
            en = ($urandom_range(0, 9) != 0);
            p  = ($urandom_range(0, 9) < 6);
            c  = ($urandom_range(0, 9) < 4);
            apply(r, en, p, DW'($urandom), c);
            check($sformatf("rand%0d", i), m_data, m_valid, q.size() == 0,
                  q.size() == DEPTH, CW'(q.size()), m_ovf);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/modulo_buffer_requisicoes.md
Name: modulo_buffer_requisicoes

Overview:
- Upstream request buffer that feeds the counter control FSM.
- Queues DATA_WIDTH-bit request values in a DEPTH-entry FIFO and presents the oldest one in an output register (reg_data) that the counter loads from.
- Drives the FSM's Load_Reg and EmptyBuffer inputs.
- Consumes the FSM's Clear_Reg pulse as its pop strobe.

Parameters:
- DATA_WIDTH, 4: width of one request value.
- DEPTH, 4: FIFO entries behind the output register. Power of two, at least 2.
- CW, $clog2(DEPTH+1): width of count.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- enable  in  1  global enable, shared with the FSM. Low means all state frozen and push/pop ignored.
- push  in  1  request strobe; data_in is sampled when push=1.
- data_in  in  DATA_WIDTH  request value.
- Clear_Reg  in  1  pop strobe from the FSM; consumes reg_data.
- reg_data  out  DATA_WIDTH  output register contents, the counter load value.
- Load_Reg  out  1  reg_data holds a valid request.
- EmptyBuffer  out  1  FIFO behind the register holds zero entries.
- FullBuffer  out  1  FIFO holds DEPTH entries.
- count  out  CW  FIFO occupancy, excluding the register.
- overflow  out  1  one-cycle pulse when a push is dropped.

Behaviour:
- Reset (rst=0 at an edge) forces the following, regardless of enable, push or Clear_Reg:
  - reg_data=0, Load_Reg=0, EmptyBuffer=1, FullBuffer=0, count=0, overflow=0.
  - Read and write pointers cleared.
- Reset mid-operation discards all queued requests. No partial transfer survives.
- With enable=0 (and rst=1), all registers hold. overflow is forced to 0. push and Clear_Reg are ignored and not remembered.
- All outputs are registered; none depend combinationally on inputs.
- Per enabled edge, evaluate in this order:
  - free_reg = (Load_Reg=0) or (Clear_Reg=1).
  - Clear_Reg while Load_Reg=0 is harmless and has no effect beyond free_reg.
  - Register source when free_reg:
    - FIFO head, if count>0 (head is dequeued);
    - else data_in, if push (bypass; the FIFO is not written);
    - else nothing: Load_Reg<=0 and reg_data holds its old value.
  - If free_reg=0, reg_data and Load_Reg hold.
  - Push acceptance when not bypassed:
    - Enqueue at the write pointer if count<DEPTH, or if count=DEPTH and the head is dequeued this same cycle.
    - Otherwise drop the push and pulse overflow=1 for the next cycle.
  - count update: count + enqueue - dequeue. It never exceeds DEPTH and never underflows.
  - Pointers wrap modulo DEPTH.
  - EmptyBuffer = (count==0) and FullBuffer = (count==DEPTH), both from registered count.
- Latency:
  - Push into a fully idle block: Load_Reg=1 and reg_data=value at the next edge (1 cycle).
  - Push while the register is occupied: the value waits in the FIFO and reaches reg_data one edge after the Clear_Reg that frees the register.
- Back-to-back pops: Clear_Reg held high with count>0 delivers one new request per cycle in FIFO order.
- Order is strictly first-in first-out, including across bypass: bypass only occurs when the FIFO is empty.
- Maximum stored requests: DEPTH+1.

Test Plan:
1. Reset and idle: rst=0 for 2 cycles with push=1 -> Load_Reg=0, EmptyBuffer=1, count=0, reg_data=0. Release rst with push=0 -> outputs unchanged.
2. Bypass then queue: push 3 on consecutive cycles (values 5, 9, 2).
   - After edge 1: reg_data=5, Load_Reg=1, EmptyBuffer=1.
   - After edge 3: count=2, EmptyBuffer=0.
   - Pulse Clear_Reg -> next edge reg_data=9, count=1.
3. Full and overflow (DEPTH=4): fill with 1, 2, 3, 4, 5 -> reg_data=1, count=4, FullBuffer=1.
   - Push 6 -> dropped, overflow=1 for exactly one cycle, count=4.
   - Push 7 together with Clear_Reg -> reg_data=2, 7 accepted, count=4, overflow=0.
4. Continuous pop: after scenario 3, hold Clear_Reg=1 -> reg_data sequence 3, 4, 5, 7, then Load_Reg=0 with EmptyBuffer=1. No duplicates, no skips, and pointer wrap is exercised.
5. Enable freeze: with count=2, hold enable=0 for 3 cycles while pulsing push and Clear_Reg -> no output change. Re-enable -> state identical to before the freeze.
6. Reset mid-operation: with count=3 and Load_Reg=1, assert rst=0 for one edge alongside push=1 and Clear_Reg=1 -> all outputs at reset values, and the push is not captured.
